// File: rtl/data_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter_pkg
// Shared definitions for the Data_Mem arbiter slice: default geometry,
// requester IDs (used as bit positions in the 2-bit request/grant vectors),
// clear-FSM state encoding and the round-robin pick helper.
// -----------------------------------------------------------------------------
package data_mem_arbiter_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 64;
    localparam int DEF_RD_LAT = 1;

    // Requester IDs; also the bit index inside {host, cpu} vectors.
    localparam logic REQ_CPU  = 1'b0;
    localparam logic REQ_HOST = 1'b1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    // One-hot pick between two requesters. ptr names the owner that wins a
    // contested cycle; an uncontested request always wins.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic ptr);
        logic [1:0] pick;
        if (req == 2'b11) begin
            pick = ptr ? 2'b10 : 2'b01;
        end else begin
            pick = req;
        end
        return pick;
    endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter with its own pointer flop. The winner is
// offered combinationally on win_o; the parent decides whether the grant is
// actually issued (take_i). The pointer only moves when a contested grant is
// taken, and then it moves to the loser.
// Ports:
//   clk_i   clock
//   rst_ni  async reset, active low (pointer -> CPU)
//   req_i   {host, cpu} requests
//   take_i  parent issued the grant offered on win_o this cycle
//   win_o   one-hot winner {host, cpu}
// -----------------------------------------------------------------------------
module rr_arb2
    import data_mem_arbiter_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       take_i,
    output logic [1:0] win_o
);

    logic ptr_q;
    logic ptr_d;

    assign win_o = rr_pick(req_i, ptr_q);

    always_comb begin
        ptr_d = ptr_q;
        if (take_i && (req_i == 2'b11)) begin
            ptr_d = ~ptr_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= REQ_CPU;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
// Sole owner of the dual-port Data_Mem (port A write, port B read, registered
// read of RD_LAT cycles). Shares it between the CPU MEM stage (c_*) and the
// host/debug interface (h_*), and runs a zero-fill CLEAR sequence on request.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   c_req/c_we/c_addr/c_wdata      CPU request (held until c_gnt)
//   c_gnt, c_rvalid, c_rdata       CPU grant (comb), read return
//   h_*                            same set for the host requester
//   clr_start                      pulse: zero every word
//   clr_busy, clr_done             clear in progress, completion pulse
//   mem_addra/mem_dina/mem_wea     Data_Mem write port
//   mem_addrb/mem_doutb            Data_Mem read port
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | normal arbitration, grants issued combinationally
// ST_CLEAR | writing zero to address cnt_q each cycle, no grants
// -----------------------------------------------------------------------------
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] h_rdata,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] mem_addra,
    output logic [DATA_W-1:0] mem_dina,
    output logic              mem_wea,
    output logic [ADDR_W-1:0] mem_addrb,
    input  logic [DATA_W-1:0] mem_doutb
);

    clr_state_t        state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              clr_done_q;

    logic [1:0]        wr_req;
    logic [1:0]        rd_req;
    logic [1:0]        wr_win;
    logic [1:0]        rd_win;
    logic [1:0]        wr_gnt;
    logic [1:0]        rd_gnt;
    logic              wr_take;
    logic              rd_take;
    logic              grant_ok;
    logic              collide;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;

    logic [RD_LAT-1:0] rv_q;
    logic [RD_LAT-1:0] rtag_q;

    assign wr_req = {h_req & h_we,  c_req & c_we};
    assign rd_req = {h_req & ~h_we, c_req & ~c_we};

    // clr_start takes priority over both requesters in the cycle it arrives.
    assign grant_ok = (state_q == ST_IDLE) && !clr_start;

    rr_arb2 u_arb_wr (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .req_i  (wr_req),
        .take_i (wr_take),
        .win_o  (wr_win)
    );

    rr_arb2 u_arb_rd (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .req_i  (rd_req),
        .take_i (rd_take),
        .win_o  (rd_win)
    );

    assign wr_addr = wr_win[REQ_HOST] ? h_addr : c_addr;
    assign rd_addr = rd_win[REQ_HOST] ? h_addr : c_addr;

    // Read and write to the same word in one cycle: the write goes first and
    // the read is held off, so the BRAM never sees an A/B address collision.
    assign collide = (|wr_win) && (|rd_win) && (wr_addr == rd_addr);

    assign wr_gnt  = grant_ok ? wr_win : 2'b00;
    assign rd_gnt  = (grant_ok && !collide) ? rd_win : 2'b00;
    assign wr_take = |wr_gnt;
    assign rd_take = |rd_gnt;

    assign c_gnt = wr_gnt[REQ_CPU]  | rd_gnt[REQ_CPU];
    assign h_gnt = wr_gnt[REQ_HOST] | rd_gnt[REQ_HOST];

    always_comb begin
        mem_wea   = 1'b0;
        mem_addra = '0;
        mem_dina  = '0;
        mem_addrb = rd_take ? rd_addr : '0;
        if (state_q == ST_CLEAR) begin
            mem_wea   = 1'b1;
            mem_addra = cnt_q;
        end else if (wr_take) begin
            mem_wea   = 1'b1;
            mem_addra = wr_addr;
            mem_dina  = wr_gnt[REQ_HOST] ? h_wdata : c_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            clr_done_q <= 1'b0;
        end else begin
            clr_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (clr_start) begin
                        state_q <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    // Counter wraps to 0 naturally after the last address.
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == {ADDR_W{1'b1}}) begin
                        state_q    <= ST_IDLE;
                        clr_done_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign clr_busy = (state_q == ST_CLEAR);
    assign clr_done = clr_done_q;

    // Tag pipe tracks which requester owns the data arriving on mem_doutb.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rv_q   <= '0;
            rtag_q <= '0;
        end else begin
            rv_q[0]   <= rd_take;
            rtag_q[0] <= rd_gnt[REQ_HOST];
            for (int i = 1; i < RD_LAT; i++) begin
                rv_q[i]   <= rv_q[i-1];
                rtag_q[i] <= rtag_q[i-1];
            end
        end
    end

    assign c_rvalid = rv_q[RD_LAT-1] && (rtag_q[RD_LAT-1] == REQ_CPU);
    assign h_rvalid = rv_q[RD_LAT-1] && (rtag_q[RD_LAT-1] == REQ_HOST);
    assign c_rdata  = c_rvalid ? mem_doutb : '0;
    assign h_rdata  = h_rvalid ? mem_doutb : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
// Directed bench for data_mem_arbiter with a behavioural 256x64 Data_Mem
// (synchronous write on A, 1-cycle registered read on B). Inputs change on
// the falling edge; combinational grants are sampled 1 time unit later and
// registered outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        c_req, c_we, h_req, h_we;
    logic [7:0]  c_addr, h_addr;
    logic [63:0] c_wdata, h_wdata;
    logic        c_gnt, c_rvalid, h_gnt, h_rvalid;
    logic [63:0] c_rdata, h_rdata;
    logic        clr_start, clr_busy, clr_done;
    logic [7:0]  mem_addra, mem_addrb;
    logic [63:0] mem_dina, mem_doutb;
    logic        mem_wea;

    logic [63:0] mem [0:255];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    data_mem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .c_req     (c_req),
        .c_we      (c_we),
        .c_addr    (c_addr),
        .c_wdata   (c_wdata),
        .c_gnt     (c_gnt),
        .c_rvalid  (c_rvalid),
        .c_rdata   (c_rdata),
        .h_req     (h_req),
        .h_we      (h_we),
        .h_addr    (h_addr),
        .h_wdata   (h_wdata),
        .h_gnt     (h_gnt),
        .h_rvalid  (h_rvalid),
        .h_rdata   (h_rdata),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .mem_addra (mem_addra),
        .mem_dina  (mem_dina),
        .mem_wea   (mem_wea),
        .mem_addrb (mem_addrb),
        .mem_doutb (mem_doutb)
    );

    always @(posedge clk) begin
        if (mem_wea) mem[mem_addra] <= mem_dina;
        mem_doutb <= mem[mem_addrb];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_host(input logic [63:0] v);
        int miss;
        miss = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            h_req = 1'b1; h_we = 1'b1; h_addr = i[7:0]; h_wdata = v;
            #1;
            if (h_gnt !== 1'b1) miss++;
        end
        @(negedge clk);
        h_req = 1'b0; h_we = 1'b0;
        chk("fill_gnt_miss", 64'(miss), 64'd0);
    endtask

    // CPU reads every address back-to-back; words below split must be lo,
    // the rest hi.
    task automatic read_all(input logic [63:0] lo, input logic [63:0] hi, input int split,
                            output int bad, output int nv);
        bad = 0;
        nv  = 0;
        for (int i = 0; i <= 256; i++) begin
            @(negedge clk);
            if (i > 0) begin
                if (c_rvalid === 1'b1) nv++;
                if (c_rdata !== (((i - 1) < split) ? lo : hi)) bad++;
            end
            if (i < 256) begin
                c_req = 1'b1; c_we = 1'b0; c_addr = i[7:0];
            end else begin
                c_req = 1'b0;
            end
            #1;
            if (i < 256 && c_gnt !== 1'b1) bad++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt, done_cnt, gnt_busy, bad, nv, found, dseen;

        rst_n = 1'b0; c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0; clr_start = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_clr_busy", clr_busy, 0);
        chk("rst_clr_done", clr_done, 0);
        chk("rst_mem_wea",  mem_wea, 0);
        chk("rst_c_gnt",    c_gnt, 0);
        chk("rst_c_rvalid", c_rvalid, 0);
        chk("rst_h_rvalid", h_rvalid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: CPU writes 0..4, then reads them back-to-back
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            c_req = 1'b1; c_we = 1'b1; c_addr = i[7:0]; c_wdata = 64'hA0 + 64'(i);
            #1;
            chk("t1_wr_gnt", c_gnt, 1);
            chk("t1_wr_addra", mem_addra, 64'(i));
            chk("t1_wr_wea", mem_wea, 1);
        end
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("t1_rvalid", c_rvalid, 1);
                chk("t1_rdata", c_rdata, 64'hA0 + 64'(i - 1));
            end else begin
                chk("t1_no_rvalid_after_wr", c_rvalid, 0);
            end
            if (i < 5) begin
                c_we = 1'b0; c_addr = i[7:0];
                #1;
                chk("t1_rd_gnt", c_gnt, 1);
            end else begin
                c_req = 1'b0;
            end
        end
        @(negedge clk);
        chk("t1_rvalid_end", c_rvalid, 0);
        chk("t1_rdata_zero", c_rdata, 0);

        // 2: contested writes, pointer alternates
        @(negedge clk);
        c_req = 1'b1; c_we = 1'b1; c_addr = 8'd5; c_wdata = 64'h11;
        h_req = 1'b1; h_we = 1'b1; h_addr = 8'd6; h_wdata = 64'h22;
        #1;
        chk("t2a_c_gnt", c_gnt, 1);
        chk("t2a_h_gnt", h_gnt, 0);
        @(negedge clk);
        c_req = 1'b0;
        #1;
        chk("t2a_h_gnt2", h_gnt, 1);
        @(negedge clk);
        c_req = 1'b1;
        #1;
        chk("t2b_h_gnt", h_gnt, 1);
        chk("t2b_c_gnt", c_gnt, 0);
        @(negedge clk);
        h_req = 1'b0;
        #1;
        chk("t2b_c_gnt2", c_gnt, 1);
        @(negedge clk);
        c_req = 1'b1; c_we = 1'b0; c_addr = 8'd5;
        #1;
        chk("t2_rd5_gnt", c_gnt, 1);
        @(negedge clk);
        c_req = 1'b0;
        h_req = 1'b1; h_we = 1'b0; h_addr = 8'd6;
        chk("t2_rd5_rvalid", c_rvalid, 1);
        chk("t2_rd5_data", c_rdata, 64'h11);
        #1;
        chk("t2_rd6_gnt", h_gnt, 1);
        @(negedge clk);
        h_req = 1'b0;
        chk("t2_rd6_h_rvalid", h_rvalid, 1);
        chk("t2_rd6_c_rvalid", c_rvalid, 0);
        chk("t2_rd6_data", h_rdata, 64'h22);

        // 3: same-address read/write, write first
        @(negedge clk);
        c_req = 1'b1; c_we = 1'b0; c_addr = 8'd7;
        h_req = 1'b1; h_we = 1'b1; h_addr = 8'd7; h_wdata = 64'hBEEF;
        #1;
        chk("t3_h_gnt", h_gnt, 1);
        chk("t3_c_gnt", c_gnt, 0);
        @(negedge clk);
        h_req = 1'b0; h_we = 1'b0;
        #1;
        chk("t3_c_gnt_next", c_gnt, 1);
        @(negedge clk);
        c_req = 1'b0;
        chk("t3_rvalid", c_rvalid, 1);
        chk("t3_rdata", c_rdata, 64'hBEEF);

        // 4: read 8 and write 9 in the same cycle
        @(negedge clk);
        c_req = 1'b1; c_we = 1'b1; c_addr = 8'd8; c_wdata = 64'h88;
        #1;
        chk("t4_pre_gnt", c_gnt, 1);
        @(negedge clk);
        c_we = 1'b0; c_addr = 8'd8;
        h_req = 1'b1; h_we = 1'b1; h_addr = 8'd9; h_wdata = 64'h99;
        #1;
        chk("t4_c_gnt", c_gnt, 1);
        chk("t4_h_gnt", h_gnt, 1);
        chk("t4_addra", mem_addra, 9);
        chk("t4_addrb", mem_addrb, 8);
        @(negedge clk);
        c_req = 1'b0; h_req = 1'b0; h_we = 1'b0;
        chk("t4_rvalid", c_rvalid, 1);
        chk("t4_rdata", c_rdata, 64'h88);

        // 5: fill with FF, clear with CPU request held, restart attempt ignored
        fill_host(64'hFF);
        @(negedge clk);
        clr_start = 1'b1; c_req = 1'b1; c_we = 1'b0; c_addr = 8'd3;
        #1;
        chk("t5_start_no_gnt", c_gnt, 0);
        busy_cnt = 0; done_cnt = 0; gnt_busy = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            clr_start = (k == 50);
            #1;
            if (clr_busy === 1'b1) busy_cnt++;
            if (clr_busy === 1'b1 && c_gnt === 1'b1) gnt_busy++;
            if (clr_done === 1'b1) begin
                done_cnt++;
                chk("t5_gnt_resume", c_gnt, 1);
                break;
            end
        end
        chk("t5_busy_cycles", 64'(busy_cnt), 256);
        chk("t5_done_count", 64'(done_cnt), 1);
        chk("t5_no_gnt_busy", 64'(gnt_busy), 0);
        @(negedge clk);
        c_req = 1'b0; clr_start = 1'b0;
        chk("t5_done_once", clr_done, 0);
        chk("t5_rvalid", c_rvalid, 1);
        chk("t5_rdata", c_rdata, 0);
        read_all(64'h0, 64'h0, 256, bad, nv);
        chk("t5_read_bad", 64'(bad), 0);
        chk("t5_read_nvalid", 64'(nv), 256);

        // 6: reset at clear count 100
        fill_host(64'hFF);
        @(negedge clk);
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        found = 0;
        for (int k = 0; k < 300; k++) begin
            #1;
            if (clr_busy === 1'b1 && mem_addra == 8'd100) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        chk("t6_reached_100", 64'(found), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_busy_low", clr_busy, 0);
        chk("t6_wea_low", mem_wea, 0);
        chk("t6_addra_zero", mem_addra, 0);
        chk("t6_done_low", clr_done, 0);
        dseen = 0;
        repeat (3) begin
            @(negedge clk);
            if (clr_done !== 1'b0) dseen++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (clr_done !== 1'b0 || clr_busy !== 1'b0) dseen++;
        end
        chk("t6_no_done", 64'(dseen), 0);
        read_all(64'h0, 64'hFF, 100, bad, nv);
        chk("t6_read_bad", 64'(bad), 0);
        chk("t6_read_nvalid", 64'(nv), 256);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
